// File: rtl/fir_tap_sequencer.sv
// Tap sequencer for a time-multiplexed FIR: one shift strobe per sample, then
// N MAC cycles walking the tap index, with a one-deep pending sample buffer.
module fir_tap_sequencer #(
    parameter int N  = 21,
    parameter int NB = 18,
    parameter int TW = 5
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic          i_valid,
    input  logic [NB-1:0] i_data,
    input  logic          i_ovr_clr,
    output logic          o_shift_valid,
    output logic [NB-1:0] o_shift_data,
    output logic [TW-1:0] o_tap_sel,
    output logic          o_acc_clr,
    output logic          o_acc_en,
    output logic          o_acc_last,
    output logic          o_busy,
    output logic          o_ready,
    output logic          o_overrun
);

    typedef enum logic [1:0] {IDLE, SHIFT, MAC} state_t;

    localparam logic [TW-1:0] LAST_TAP = TW'(N - 1);

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_tap, w_tap_nxt;
    logic          r_pend_valid, w_pend_valid_nxt;
    logic [NB-1:0] r_pend_data, w_pend_data_nxt;
    logic [NB-1:0] w_shift_data_nxt;
    logic          w_overrun_nxt;
    logic          w_last_tap, w_accept, w_drop;

    // The final MAC cycle frees the pending slot, so it can take a sample then.
    assign w_last_tap = (r_state == MAC) && (r_tap == LAST_TAP);
    assign o_ready    = ~r_pend_valid | (w_last_tap & i_enable);
    assign w_accept   = i_enable & i_valid & o_ready;
    assign w_drop     = i_enable & i_valid & ~o_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        w_state_nxt      = r_state;
        w_tap_nxt        = r_tap;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
        w_shift_data_nxt = o_shift_data;

        if (i_enable) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_shift_data_nxt = i_data;
                        w_state_nxt      = SHIFT;
                    end
                end
                SHIFT: begin
                    w_state_nxt = MAC;
                    w_tap_nxt   = '0;
                    if (w_accept) begin
                        w_pend_valid_nxt = 1'b1;
                        w_pend_data_nxt  = i_data;
                    end
                end
                MAC: begin
                    if (r_tap == LAST_TAP) begin
                        w_tap_nxt = '0;
                        if (r_pend_valid) begin
                            // Pending is older and wins; a same-cycle sample refills it.
                            w_shift_data_nxt = r_pend_data;
                            w_state_nxt      = SHIFT;
                            w_pend_valid_nxt = w_accept;
                            if (w_accept) w_pend_data_nxt = i_data;
                        end else if (w_accept) begin
                            w_shift_data_nxt = i_data;
                            w_state_nxt      = SHIFT;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_tap_nxt = r_tap + TW'(1);
                        if (w_accept) begin
                            w_pend_valid_nxt = 1'b1;
                            w_pend_data_nxt  = i_data;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        if (w_drop)
            w_overrun_nxt = 1'b1;
        else if (i_enable & i_ovr_clr)
            w_overrun_nxt = 1'b0;
        else
            w_overrun_nxt = o_overrun;
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_tap         <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_data   <= '0;
            o_shift_data  <= '0;
            o_shift_valid <= 1'b0;
            o_tap_sel     <= '0;
            o_acc_clr     <= 1'b0;
            o_acc_en      <= 1'b0;
            o_acc_last    <= 1'b0;
            o_busy        <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state       <= w_state_nxt;
            r_tap         <= w_tap_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_data   <= w_pend_data_nxt;
            o_shift_data  <= w_shift_data_nxt;
            o_overrun     <= w_overrun_nxt;
            o_shift_valid <= i_enable && (w_state_nxt == SHIFT);
            o_acc_en      <= i_enable && (w_state_nxt == MAC);
            o_acc_clr     <= i_enable && (w_state_nxt == MAC) && (w_tap_nxt == '0);
            o_acc_last    <= i_enable && (w_state_nxt == MAC) && (w_tap_nxt == LAST_TAP);
            o_tap_sel     <= (w_state_nxt == MAC) ? w_tap_nxt : '0;
            o_busy        <= (w_state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed testbench for fir_tap_sequencer; cycle 0 is the first cycle after
// reset release, inputs change at posedge+1 and outputs are sampled at posedge+3.
module tb_fir_tap_sequencer;

    localparam int N  = 21;
    localparam int NB = 18;
    localparam int TW = 5;
    localparam int P  = N + 1;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_enable = 1'b0;
    logic          i_valid = 1'b0;
    logic [NB-1:0] i_data = '0;
    logic          i_ovr_clr = 1'b0;
    logic          o_shift_valid;
    logic [NB-1:0] o_shift_data;
    logic [TW-1:0] o_tap_sel;
    logic          o_acc_clr, o_acc_en, o_acc_last, o_busy, o_ready, o_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    fir_tap_sequencer #(.N(N), .NB(NB), .TW(TW)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_valid(i_valid), .i_data(i_data), .i_ovr_clr(i_ovr_clr),
        .o_shift_valid(o_shift_valid), .o_shift_data(o_shift_data),
        .o_tap_sel(o_tap_sel), .o_acc_clr(o_acc_clr), .o_acc_en(o_acc_en),
        .o_acc_last(o_acc_last), .o_busy(o_busy), .o_ready(o_ready),
        .o_overrun(o_overrun)
    );

    always #5 i_clock = ~i_clock;

    // Control bundle {shift_valid, acc_clr, acc_en, acc_last, busy, tap_sel}.
    logic [TW+4:0] w_ctrl;
    assign w_ctrl = {o_shift_valid, o_acc_clr, o_acc_en, o_acc_last, o_busy, o_tap_sel};

    function automatic logic [TW+4:0] pack(bit sv, bit clr, bit en, bit last, bit busy, int tap);
        return {sv, clr, en, last, busy, TW'(tap)};
    endfunction

    // Expected control for ns samples served back to back from cycle 0.
    function automatic logic [TW+4:0] exp_chain(int c, int ns);
        int m;
        if (c < 1 || c > ns * P) return '0;
        m = (c - 1) % P;
        if (m == 0) return pack(1, 0, 0, 0, 1, 0);
        return pack(0, m == 1, 1, m == N, 1, m - 1);
    endfunction

    task automatic do_reset();
        i_reset = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_data = '0; i_ovr_clr = 1'b0;
        repeat (2) @(posedge i_clock);
        #1 i_reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        #1;
        n_tests++;
        if (w_ctrl !== '0 || o_shift_data !== '0 || o_overrun !== 1'b0 || o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state ctrl=%b data=%h ovr=%b ready=%b want ctrl=0 data=0 ovr=0 ready=1",
                     w_ctrl, o_shift_data, o_overrun, o_ready);
        end
    endtask

    task automatic test_single();
        logic [TW+4:0] e;
        do_reset();
        for (int c = 0; c <= 24; c++) begin
            i_valid = (c == 0);
            i_data  = 18'h00ABC;
            #2;
            e = exp_chain(c, 1);
            n_tests++;
            if (w_ctrl !== e) begin
                n_fail++;
                $display("FAIL single_ctrl c=%0d got %b want %b", c, w_ctrl, e);
            end
            if (c == 1) begin
                n_tests++;
                if (o_shift_data !== 18'h00ABC) begin
                    n_fail++;
                    $display("FAIL single_data got %h want 00abc", o_shift_data);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0] smp [5] = '{18'h00001, 18'h3FFFF, 18'h12345, 18'h2AAAA, 18'h15555};
        logic [TW+4:0] e;
        int strobes = 0;
        do_reset();
        for (int c = 0; c <= 4 * P + 24; c++) begin
            i_valid = (c % P == 0) && (c <= 4 * P);
            i_data  = smp[(c / P) % 5];
            #2;
            e = exp_chain(c, 5);
            n_tests++;
            if (w_ctrl !== e || o_overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_ctrl c=%0d got %b ovr=%b want %b ovr=0", c, w_ctrl, o_overrun, e);
            end
            if (o_shift_valid === 1'b1) begin
                n_tests++;
                if (strobes >= 5 || o_shift_data !== smp[strobes % 5]) begin
                    n_fail++;
                    $display("FAIL b2b_data c=%0d got %h want %h", c, o_shift_data, smp[strobes % 5]);
                end
                strobes++;
            end
            next_cycle();
        end
        n_tests++;
        if (strobes != 5) begin
            n_fail++;
            $display("FAIL b2b_count got %0d want 5", strobes);
        end
    endtask

    // C offered at cycle 6 (dropped) or at the last tap, cycle 22 (kept).
    task automatic test_pending(input bit c_at_last);
        logic [NB-1:0] smp [3] = '{18'h0000A, 18'h0000B, 18'h0000C};
        logic [TW+4:0] e;
        bit e_ready, e_ovr;
        int ns, strobes, c_cyc;
        ns = c_at_last ? 3 : 2;
        c_cyc = c_at_last ? N + 1 : 6;
        strobes = 0;
        do_reset();
        for (int c = 0; c <= ns * P + 2; c++) begin
            i_valid = (c == 0) || (c == 5) || (c == c_cyc);
            i_data  = (c == 0) ? smp[0] : (c == 5) ? smp[1] : smp[2];
            #2;
            e = exp_chain(c, ns);
            e_ready = !((c >= 6 && c <= N) || (c_at_last && c >= P + 1 && c <= 2 * P - 1));
            e_ovr   = !c_at_last && (c >= 7);
            n_tests++;
            if (w_ctrl !== e || o_ready !== e_ready || o_overrun !== e_ovr) begin
                n_fail++;
                $display("FAIL pending%0d c=%0d ctrl=%b ready=%b ovr=%b want ctrl=%b ready=%b ovr=%b",
                         c_at_last, c, w_ctrl, o_ready, o_overrun, e, e_ready, e_ovr);
            end
            if (o_shift_valid === 1'b1) begin
                n_tests++;
                if (strobes >= ns || o_shift_data !== smp[strobes % 3]) begin
                    n_fail++;
                    $display("FAIL pending%0d_data c=%0d got %h want %h",
                             c_at_last, c, o_shift_data, smp[strobes % 3]);
                end
                strobes++;
            end
            next_cycle();
        end
        n_tests++;
        if (strobes != ns) begin
            n_fail++;
            $display("FAIL pending%0d_count got %0d want %0d", c_at_last, strobes, ns);
        end
    endtask

    task automatic test_enable_stall();
        logic [TW+4:0] e;
        do_reset();
        for (int c = 0; c <= 27; c++) begin
            i_enable = !(c >= 9 && c <= 11);
            i_valid  = (c == 0) || (c >= 9 && c <= 11);
            i_data   = 18'h01F00 + NB'(c);
            #2;
            if (c == 1)                  e = pack(1, 0, 0, 0, 1, 0);
            else if (c >= 2 && c <= 9)   e = pack(0, c == 2, 1, 0, 1, c - 2);
            else if (c >= 10 && c <= 12) e = pack(0, 0, 0, 0, 1, 7);
            else if (c >= 13 && c <= 25) e = pack(0, 0, 1, c == 25, 1, c - 5);
            else                         e = '0;
            n_tests++;
            if (w_ctrl !== e || o_overrun !== 1'b0) begin
                n_fail++;
                $display("FAIL stall c=%0d got %b ovr=%b want %b ovr=0", c, w_ctrl, o_overrun, e);
            end
            next_cycle();
        end
        i_enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [TW+4:0] e;
        do_reset();
        for (int c = 0; c <= 14; c++) begin
            i_valid = (c == 0) || (c == 3);
            i_data  = (c == 0) ? 18'h00111 : 18'h00222;
            #2;
            e = exp_chain(c, 1);
            n_tests++;
            if (w_ctrl !== e || (c == 14 && o_ready !== 1'b0)) begin
                n_fail++;
                $display("FAIL pre_reset c=%0d got %b ready=%b want %b", c, w_ctrl, o_ready, e);
            end
            if (c < 14) next_cycle();
        end
        i_valid = 1'b0;
        test_reset();
        next_cycle();
        i_reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            #2;
            n_tests++;
            if (w_ctrl !== '0) begin
                n_fail++;
                $display("FAIL post_reset c=%0d got %b want 0 (pending discarded)", c, w_ctrl);
            end
            next_cycle();
        end
    endtask

    task automatic test_ovr_clr();
        bit e_ovr;
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            i_valid   = (c <= 2) || (c == 5);
            i_data    = NB'(c + 1);
            i_ovr_clr = (c == 5) || (c == 7);
            #2;
            e_ovr = (c >= 3 && c <= 7);
            n_tests++;
            if (o_overrun !== e_ovr) begin
                n_fail++;
                $display("FAIL ovr_clr c=%0d got %b want %b", c, o_overrun, e_ovr);
            end
            next_cycle();
        end
        i_valid = 1'b0; i_ovr_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_pending(1'b0);
        test_pending(1'b1);
        test_enable_stall();
        test_reset_mid();
        test_ovr_clr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Controller for the time-multiplexed FIR datapath built around the tap delay line (shift register, N words of NB bits) and a single shared MAC. Accepts input samples, issues one shift strobe per sample to the delay line, then walks the tap index 0..N-1 to drive the coefficient ROM and tap mux. It also generates accumulator clear, enable and last-tap controls. A one-deep pending buffer absorbs a sample arriving mid-sequence; further samples are dropped and flagged.

Parameters:
N, 21, number of taps (delay line length); N >= 2
NB, 18, sample word width
TW, 5, tap index width; 2^TW >= N

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous reset, active-high
i_enable  in  1  global run; 0 freezes all state
i_valid  in  1  input sample valid
i_data  in  NB  input sample
i_ovr_clr  in  1  synchronous clear of o_overrun
o_shift_valid  out  1  one-cycle shift strobe to delay line (drives its enable/valid)
o_shift_data  out  NB  sample to insert into delay line
o_tap_sel  out  TW  tap index / coefficient address
o_acc_clr  out  1  accumulator clear, with tap 0
o_acc_en  out  1  accumulate this cycle
o_acc_last  out  1  final tap; MAC result is valid after this cycle
o_busy  out  1  state != IDLE
o_ready  out  1  a sample offered now is accepted
o_overrun  out  1  sticky: a sample was dropped

Behaviour:
- Reset (async, i_reset=1): state IDLE, tap counter 0, pending empty, all outputs 0 except o_ready=1; o_shift_data=0.
- Accept condition: i_enable & i_valid & o_ready. All outputs are registered except o_ready.
- o_ready = ~pending_valid | (state==MAC & tap==N-1 & i_enable).
- FSM states: IDLE, SHIFT, MAC.
- IDLE: on accept, latch i_data into o_shift_data and go to SHIFT.
- SHIFT (1 cycle): o_shift_valid=1, o_tap_sel=0, o_acc_*=0; then go to MAC with tap=0.
- MAC (N cycles): o_acc_en=1, o_tap_sel=tap; o_acc_clr=1 only at tap 0; o_acc_last=1 only at tap N-1. Tap increments by 1 per enabled cycle.
  - At tap N-1: if pending_valid, move pending to o_shift_data and go to SHIFT; else if accept this cycle, latch i_data and go to SHIFT; else go to IDLE with tap=0.
  - Pending is older and always wins. If pending is valid and a new sample is accepted in the same cycle, the new sample refills pending. This is not an overrun.
- Accept during SHIFT or MAC with tap < N-1 and pending empty: store in pending.
- Offer while o_ready=0 (i_enable & i_valid & ~o_ready): sample dropped, o_overrun set.
- i_ovr_clr clears o_overrun. If a drop occurs in the same cycle, set wins.
- i_enable=0: FSM, tap counter, pending and flags hold. o_shift_valid, o_acc_en, o_acc_clr and o_acc_last are forced 0 that cycle, and i_valid is ignored. On re-enable, the sequence resumes at the held tap; no tap is skipped or repeated.
- Latency: sample accepted from IDLE at cycle t gives o_shift_valid at t+1, tap 0 at t+2, and o_acc_last at t+1+N.
- Sustained throughput: one sample per N+1 enabled cycles. Back-to-back service goes MAC(N-1) -> SHIFT with no IDLE gap.
- Tap counter never exceeds N-1. o_tap_sel=0 outside MAC.
- Reset mid-sequence: immediate abort to reset values; the pending sample is discarded.

Test Plan:
- Single sample 0x00ABC from IDLE at cycle 0 -> o_shift_valid=1, o_shift_data=0x00ABC at cycle 1; o_tap_sel 0..20 on cycles 2..22; acc_clr at cycle 2 only; acc_last at cycle 22 only; IDLE and o_busy=0 at cycle 23.
- Samples every 22 cycles for 5 samples -> SHIFT directly follows each tap 20, no IDLE cycles, o_overrun=0, 5 shift strobes with data in order.
- Samples A at cycle 0, B at cycle 5, C at cycle 6 -> B held in pending, o_ready=0 from cycle 6, C dropped, o_overrun=1. Second SHIFT at cycle 23 carries B; only 2 shift strobes total.
- Pending B plus new C offered at tap 20 -> B shifted next cycle, C in pending, o_overrun stays 0, third SHIFT carries C.
- i_enable=0 for 3 cycles at tap 7 -> o_tap_sel holds 7 with o_acc_en=0 and i_valid ignored; resumes at 7 and acc_last arrives 3 cycles later than nominal.
- i_reset pulsed at tap 12 with pending valid -> all outputs 0 immediately and o_ready=1. i_ovr_clr with o_overrun=1 and no drop -> o_overrun=0 next cycle.
